trdb_trigger: RTL and testbench
===============================

// Module: trdb_trigger
// PURPOSE
// Trace start/stop trigger unit. Watches the retired-instruction stream and
// raises single-cycle trace-on / trace-off requests. Sits directly upstream
// of the encoder's control register block, which consumes these pulses as
// its trace-on/trace-off requests to set or clear trace enable.
// Supports address start/stop triggers, a privilege filter, an instruction
// budget and an optional auto re-arm after a hold-off window.
// PARAMETERS
// XLEN     32  width of instruction address
// CNT_W    16  width of retired-instruction budget counter
// HOLDOFF  4   cycles spent in HOLD after a stop before re-arming (>=1)
// PORTS
// clk_i            in   1       clock
// rst_i            in   1       reset, asynchronous, active-high
// arm_i            in   1       pulse: IDLE -> ARMED
// disarm_i         in   1       pulse: any state -> IDLE (priority over arm_i)
// auto_rearm_i     in   1       1: HOLD returns to ARMED; 0: HOLD returns to IDLE
// start_addr_i     in   XLEN    start-trigger address
// stop_addr_i      in   XLEN    stop-trigger address
// max_instr_i      in   CNT_W   instruction budget; 0 = unlimited
// priv_mask_i      in   4       bit n set = privilege level n qualifies
// iretire_i        in   1       one instruction retired this cycle
// iaddr_i          in   XLEN    address of the retired instruction
// priv_i           in   2       privilege level of the retired instruction
// trace_req_on_o   out  1       1-cycle pulse: request tracing on
// trace_req_off_o  out  1       1-cycle pulse: request tracing off
// state_o          out  2       IDLE=0 ARMED=1 TRACING=2 HOLD=3
// instr_cnt_o      out  CNT_W   qualifying retires counted in the current window
// BEHAVIOUR
// - Reset: state IDLE, instr_cnt_o=0, hold counter=0, both req outputs 0.
//   Reset mid-window drops the window silently; no off pulse is issued.
// - Qualifying retire (qret) = iretire_i & priv_mask_i[priv_i].
//   Non-qualifying retires are invisible: no match, no count.
// - All outputs are registered. Each req pulse appears in the cycle after
//   the qret that caused it (latency 1) and lasts exactly 1 cycle.
// - IDLE:    arm_i & ~disarm_i -> ARMED.
// - ARMED:   qret & iaddr_i==start_addr_i -> TRACING, req_on pulse,
//            cnt := 1. Same-cycle arm_i is ignored.
// - TRACING: on each qret, stop if iaddr_i==stop_addr_i, or if
//            max_instr_i!=0 and cnt+1 >= max_instr_i.
//            Stop -> HOLD, req_off pulse, hold counter := HOLDOFF-1.
//            Otherwise cnt += 1, saturating at all-ones.
//            The start instruction is never tested against stop_addr
//            (start==stop gives a window of >=2 instructions).
// - HOLD:    hold counter decrements each cycle; at 0 ->
//            ARMED if auto_rearm_i, else IDLE. qret is ignored in HOLD.
//            cnt keeps its final value until the next start.
// - disarm_i in any state -> IDLE next cycle. In TRACING it also issues a
//   req_off pulse. disarm_i has priority over any same-cycle trigger.
// - req_on and req_off are never asserted in the same cycle.
// - max_instr_i, the addresses and the mask are sampled live each cycle;
//   changing them mid-window takes effect on the next qret.
// TESTING
// 1 rst_i, arm_i, qret at start_addr=0x100 -> req_on 1 cycle later,
//   state=TRACING, cnt=1.
// 2 Tracing, max=0; qret at stop_addr=0x200 -> req_off 1 cycle later,
//   HOLD for 4 cycles, then IDLE (auto_rearm_i=0).
// 3 max_instr=5; start then 4 non-stop qrets -> req_off follows the 4th;
//   auto_rearm_i=1 -> ARMED after HOLDOFF cycles.
// 4 priv_mask=4'b0001; retires at start_addr with priv=3 -> no req_on;
//   then priv=0 -> req_on.
// 5 disarm_i together with a stop-address qret while TRACING -> one req_off,
//   state=IDLE, no HOLD.
// 6 rst_i asserted in TRACING with cnt=7 -> immediate IDLE, cnt=0, no pulses.

Source files
------------

// File: rtl/trdb_trigger.sv
// ---------------------------------------------------------------------------
// trdb_trigger
//
// Trace start/stop trigger unit. Watches the retired-instruction stream and
// raises single-cycle trace-on / trace-off requests for the encoder's
// control register block.
//
// Windows are opened by a qualifying retire at start_addr_i while ARMED. They
// are closed by any of the following:
//   - a qualifying retire at stop_addr_i,
//   - exhaustion of the instruction budget,
//   - disarm_i.
// After a stop, the unit waits HOLDOFF cycles in HOLD and then either re-arms
// or returns to IDLE.
//
// Ports
//   clk_i            clock
//   rst_i            asynchronous active-high reset
//   arm_i            pulse: IDLE -> ARMED
//   disarm_i         pulse: any state -> IDLE (wins over every other event)
//   auto_rearm_i     HOLD exit target: 1 = ARMED, 0 = IDLE
//   start_addr_i     start-trigger address
//   stop_addr_i      stop-trigger address
//   max_instr_i      instruction budget, 0 = unlimited
//   priv_mask_i      bit n set = privilege level n qualifies
//   iretire_i        one instruction retired this cycle
//   iaddr_i          address of the retired instruction
//   priv_i           privilege level of the retired instruction
//   trace_req_on_o   registered 1-cycle trace-on request
//   trace_req_off_o  registered 1-cycle trace-off request
//   state_o          IDLE=0 ARMED=1 TRACING=2 HOLD=3
//   instr_cnt_o      qualifying retires counted in the current window
// ---------------------------------------------------------------------------
module trdb_trigger #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             disarm_i,
  input  logic             auto_rearm_i,
  input  logic [XLEN-1:0]  start_addr_i,
  input  logic [XLEN-1:0]  stop_addr_i,
  input  logic [CNT_W-1:0] max_instr_i,
  input  logic [3:0]       priv_mask_i,
  input  logic             iretire_i,
  input  logic [XLEN-1:0]  iaddr_i,
  input  logic [1:0]       priv_i,
  output logic             trace_req_on_o,
  output logic             trace_req_off_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRACING = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic              req_on, req_on_n;
  logic              req_off, req_off_n;

  logic              qret;
  logic              start_hit;
  logic              stop_hit;
  logic              budget_hit;
  logic [CNT_W:0]    cnt_inc;

  // Retires from privilege levels outside the mask are invisible to the unit.
  assign qret      = iretire_i & priv_mask_i[priv_i];
  assign start_hit = qret & (iaddr_i == start_addr_i);
  assign stop_hit  = (iaddr_i == stop_addr_i);

  // One bit wider than the counter so a saturated count never wraps
  // below the budget.
  assign cnt_inc    = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign budget_hit = (max_instr_i != '0) && (cnt_inc >= {1'b0, max_instr_i});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      hold    <= '0;
      req_on  <= 1'b0;
      req_off <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hold    <= hold_n;
      req_on  <= req_on_n;
      req_off <= req_off_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hold_n    = hold;
    req_on_n  = 1'b0;
    req_off_n = 1'b0;

    if (disarm_i) begin
      // Closing an open window still has to tell the encoder to stop.
      state_n   = IDLE;
      req_off_n = (state == TRACING);
    end else begin
      case (state)
        IDLE: begin
          if (arm_i) begin
            state_n = ARMED;
          end
        end

        ARMED: begin
          if (start_hit) begin
            state_n  = TRACING;
            req_on_n = 1'b1;
            cnt_n    = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        TRACING: begin
          // The start instruction was consumed in ARMED, so it is never
          // tested against the stop address here.
          if (qret) begin
            if (stop_hit || budget_hit) begin
              state_n   = HOLD;
              req_off_n = 1'b1;
              hold_n    = HOLD_W'(HOLDOFF - 1);
            end else if (cnt != '1) begin
              cnt_n = cnt_inc[CNT_W-1:0];
            end
          end
        end

        HOLD: begin
          if (hold == '0) begin
            state_n = auto_rearm_i ? ARMED : IDLE;
          end else begin
            hold_n = hold - HOLD_W'(1);
          end
        end
      endcase
    end
  end

  assign trace_req_on_o  = req_on;
  assign trace_req_off_o = req_off;
  assign state_o         = state;
  assign instr_cnt_o     = cnt;

endmodule

// File: tb/tb_trdb_trigger.sv
// ---------------------------------------------------------------------------
// tb_trdb_trigger
//
// Self-checking bench for trdb_trigger. A small counter width is used so
// that budget and saturation corners are reachable quickly. The reference
// model tracks the trigger window with plain integers. It times the
// hold-off window by an absolute cycle stamp rather than a down-counter.
// ---------------------------------------------------------------------------
module tb_trdb_trigger;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CW      = 4;
  localparam int unsigned HOLDOFF = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            arm;
  logic            disarm;
  logic            auto_rearm;
  logic [XLEN-1:0] start_addr;
  logic [XLEN-1:0] stop_addr;
  logic [CW-1:0]   max_instr;
  logic [3:0]      priv_mask;
  logic            iretire;
  logic [XLEN-1:0] iaddr;
  logic [1:0]      priv;
  logic            req_on;
  logic            req_off;
  logic [1:0]      state;
  logic [CW-1:0]   instr_cnt;

  int total = 0;
  int bad   = 0;

  // reference model
  int m_state   = 0;
  int m_cnt     = 0;
  int m_on      = 0;
  int m_off     = 0;
  int cyc       = 0;
  int hold_exit = 0;

  trdb_trigger #(
    .XLEN    (XLEN),
    .CNT_W   (CW),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .arm_i           (arm),
    .disarm_i        (disarm),
    .auto_rearm_i    (auto_rearm),
    .start_addr_i    (start_addr),
    .stop_addr_i     (stop_addr),
    .max_instr_i     (max_instr),
    .priv_mask_i     (priv_mask),
    .iretire_i       (iretire),
    .iaddr_i         (iaddr),
    .priv_i          (priv),
    .trace_req_on_o  (req_on),
    .trace_req_off_o (req_off),
    .state_o         (state),
    .instr_cnt_o     (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one rising edge worth of inputs to the model.
  task automatic model_step();
    bit q;
    int on;
    int off;
    cyc++;
    q   = iretire && priv_mask[priv];
    on  = 0;
    off = 0;
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (disarm) begin
      off     = (m_state == 2) ? 1 : 0;
      m_state = 0;
    end else begin
      case (m_state)
        0: if (arm) m_state = 1;
        1: if (q && iaddr == start_addr) begin
             m_state = 2;
             m_cnt   = 1;
             on      = 1;
           end
        2: if (q) begin
             if (iaddr == stop_addr || (max_instr != 0 && m_cnt + 1 >= int'(max_instr))) begin
               m_state   = 3;
               off       = 1;
               hold_exit = cyc + HOLDOFF;
             end else if (m_cnt < CNT_MAX) begin
               m_cnt++;
             end
           end
        default: if (cyc >= hold_exit) m_state = auto_rearm ? 1 : 0;
      endcase
    end
    m_on  = on;
    m_off = off;
  endtask

  // One clock: edge, model update, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("state", 32'(state), 32'(m_state));
    check("cnt", 32'(instr_cnt), 32'(m_cnt));
    check("req_on", 32'(req_on), 32'(m_on));
    check("req_off", 32'(req_off), 32'(m_off));
    check("on_off_excl", 32'(req_on & req_off), 32'd0);
  endtask

  task automatic quiet();
    rst     = 1'b0;
    arm     = 1'b0;
    disarm  = 1'b0;
    iretire = 1'b0;
  endtask

  task automatic retire(input logic [XLEN-1:0] a, input logic [1:0] p);
    iretire = 1'b1;
    iaddr   = a;
    priv    = p;
  endtask

  initial begin
    quiet();
    auto_rearm = 1'b0;
    start_addr = 32'h100;
    stop_addr  = 32'h200;
    max_instr  = '0;
    priv_mask  = 4'hF;
    iaddr      = '0;
    priv       = 2'd0;

    // 1: reset, arm, start
    rst = 1'b1;
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
    quiet();
    arm = 1'b1;
    tick();
    check("t1_armed", 32'(state), 32'd1);
    quiet();
    retire(32'h100, 2'd0);
    tick();
    check("t1_on", 32'(req_on), 32'd1);
    check("t1_state", 32'(state), 32'd2);
    check("t1_cnt", 32'(instr_cnt), 32'd1);
    quiet();
    tick();
    check("t1_on_1cyc", 32'(req_on), 32'd0);

    // 2: stop address, HOLD for 4 cycles, then IDLE
    retire(32'h104, 2'd1);
    tick();
    tick();
    check("t2_cnt", 32'(instr_cnt), 32'd3);
    retire(32'h200, 2'd0);
    tick();
    check("t2_off", 32'(req_off), 32'd1);
    check("t2_hold", 32'(state), 32'd3);
    quiet();
    for (int i = 0; i < 3; i++) tick();
    check("t2_hold_last", 32'(state), 32'd3);
    tick();
    check("t2_idle", 32'(state), 32'd0);

    // 3: budget of 5, auto re-arm
    max_instr  = 4'd5;
    auto_rearm = 1'b1;
    arm = 1'b1;
    tick();
    quiet();
    retire(32'h100, 2'd0);
    tick();
    retire(32'h180, 2'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t3_no_off_yet", 32'(req_off), 32'd0);
    tick();
    check("t3_off", 32'(req_off), 32'd1);
    check("t3_cnt_kept", 32'(instr_cnt), 32'd4);
    quiet();
    for (int i = 0; i < 4; i++) tick();
    check("t3_rearmed", 32'(state), 32'd1);

    // 4: privilege filter
    priv_mask = 4'b0001;
    retire(32'h100, 2'd3);
    tick();
    check("t4_filtered", 32'(req_on), 32'd0);
    check("t4_still_armed", 32'(state), 32'd1);
    retire(32'h100, 2'd0);
    tick();
    check("t4_on", 32'(req_on), 32'd1);

    // 5: disarm with a same-cycle stop hit
    quiet();
    disarm = 1'b1;
    retire(32'h200, 2'd0);
    tick();
    check("t5_off", 32'(req_off), 32'd1);
    check("t5_idle", 32'(state), 32'd0);
    quiet();
    tick();
    check("t5_single_off", 32'(req_off), 32'd0);
    check("t5_no_hold", 32'(state), 32'd0);

    // 6: asynchronous reset mid-window
    max_instr = '0;
    arm = 1'b1;
    tick();
    quiet();
    retire(32'h100, 2'd0);
    tick();
    retire(32'h104, 2'd0);
    for (int i = 0; i < 6; i++) tick();
    check("t6_cnt7", 32'(instr_cnt), 32'd7);
    quiet();
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_state", 32'(state), 32'd0);
    check("t6_async_cnt", 32'(instr_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // randomized traffic
    priv_mask = 4'hF;
    for (int n = 0; n < 4000; n++) begin
      rst    = ($urandom_range(0, 499) == 0);
      arm    = ($urandom_range(0, 3) == 0);
      disarm = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) auto_rearm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) max_instr = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom);
      if ($urandom_range(0, 39) == 0) priv_mask = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 99) == 0) stop_addr = ($urandom_range(0, 2) == 0) ? start_addr : 32'h200;
      iretire = ($urandom_range(0, 2) != 0);
      priv    = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       iaddr = start_addr;
        1:       iaddr = stop_addr;
        default: iaddr = 32'h1000 + 32'($urandom_range(0, 255));
      endcase
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
